// File: rtl/vga_regs_pkg.sv
// Shared definitions for the VGA register-bank commit path.
//
// Contents:
//   NUM_SLOTS, V_VISIBLE           shadow slot count and first blanking line
//   SLOT_SEG_HORA..SLOT_BANDERAS   slot index of each display register
//   PORT_BASE / PORT_FLUSH / PORT_OVR_CLR
//                                  PicoBlaze port addresses for slot 0,
//                                  flush request and overwrite-flag clear
//   state_t                        commit scheduler states
//   slot_onehot()                  slot index to hold-strobe vector
package vga_regs_pkg;

    localparam int NUM_SLOTS = 10;
    localparam int V_VISIBLE = 480;

    localparam int SLOT_SEG_HORA  = 0;
    localparam int SLOT_MIN_HORA  = 1;
    localparam int SLOT_HORA_HORA = 2;
    localparam int SLOT_DIA_FECHA = 3;
    localparam int SLOT_MES_FECHA = 4;
    localparam int SLOT_JAHR      = 5;
    localparam int SLOT_SEG_TIMER = 6;
    localparam int SLOT_MIN_TIMER = 7;
    localparam int SLOT_HORA_TIM  = 8;
    localparam int SLOT_BANDERAS  = 9;

    localparam logic [7:0] PORT_BASE    = 8'h20;
    localparam logic [7:0] PORT_FLUSH   = 8'h2F;
    localparam logic [7:0] PORT_OVR_CLR = 8'h2E;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [3:0] idx);
        return NUM_SLOTS'(1) << idx;
    endfunction

endpackage

// File: rtl/slot_priority_enc.sv
// Lowest-index-first selector over the pending slot vector.
//
// Ports:
//   pending  in   N   one bit per shadow slot waiting to be committed
//   idx      out  4   index of the lowest set bit (0 when none set)
//   valid    out  1   at least one bit of pending is set
module slot_priority_enc
    import vga_regs_pkg::*;
#(
    parameter int N = NUM_SLOTS
) (
    input  logic [N-1:0] pending,
    output logic [3:0]   idx,
    output logic         valid
);

    // Scanning downward lets the lowest set bit be the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx   = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_commit_scheduler.sv
// Frame-synchronous write scheduler between the PicoBlaze port bus and the
// VGA display register bank. Port writes to 8'h20..8'h29 land in shadow
// slots; pending slots are committed to the bank one per clock, lowest index
// first, only while vertical blanking is active (or after a flush request
// written to 8'h2F), so a frame never shows a half-updated time.
//
// Optional feature: define VGA_COMMIT_OVR_EN to build the sticky
// overwrite_flag output (cleared by a write to 8'h2E).
//
// Ports:
//   clock           in   1   system clock
//   reset           in   1   asynchronous active-low reset
//   port_id         in   8   PicoBlaze port address
//   in_dato         in   8   PicoBlaze write data
//   write_strobe    in   1   PicoBlaze write qualifier
//   pixel_y         in   10  current scan line
//   hold_out        out  10  one-hot commit strobe to the register bank
//   data_out        out  8   data accompanying hold_out (holds last value)
//   busy            out  1   any slot pending
//   overwrite_flag  out  1   sticky: a pending slot was rewritten
//
// Handshake: there is no back-pressure. A write is accepted in every cycle
// write_strobe is high; a hold_out pulse is valid for exactly one cycle and
// the bank must take it in that cycle.
module vga_commit_scheduler
    import vga_regs_pkg::*;
#(
    parameter int NUM_SLOTS = vga_regs_pkg::NUM_SLOTS,
    parameter int V_VISIBLE = vga_regs_pkg::V_VISIBLE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           port_id,
    input  logic [7:0]           in_dato,
    input  logic                 write_strobe,
    input  logic [9:0]           pixel_y,
    output logic [NUM_SLOTS-1:0] hold_out,
    output logic [7:0]           data_out,
    output logic                 busy
`ifdef VGA_COMMIT_OVR_EN
    ,
    output logic                 overwrite_flag
`endif
);

    state_t                state_q, state_d;
    logic [NUM_SLOTS-1:0]  pending_q, pending_d;
    logic [7:0]            shadow_q [NUM_SLOTS];
    logic                  flush_q, flush_d;
    logic                  vblank_q;

    logic [7:0]            port_off;
    logic                  slot_wr;
    logic                  flush_wr;
    logic [3:0]            wr_idx;
    logic [NUM_SLOTS-1:0]  wr_mask;
    logic [3:0]            pri_idx;
    logic                  pri_valid;
    logic                  do_commit;

    // Addresses below the base wrap to large offsets and fail the range test.
    assign port_off = port_id - PORT_BASE;
    assign slot_wr  = write_strobe && (port_off <= 8'(SLOT_BANDERAS));
    assign flush_wr = write_strobe && (port_id == PORT_FLUSH);
    assign wr_idx   = port_off[3:0];
    assign wr_mask  = slot_wr ? slot_onehot(wr_idx) : '0;

    slot_priority_enc #(.N(NUM_SLOTS)) u_pri (
        .pending (pending_q),
        .idx     (pri_idx),
        .valid   (pri_valid)
    );

    // WAIT and COMMIT both issue a strobe in any cycle where committing is
    // allowed; WAIT -> COMMIT and COMMIT -> WAIT only track whether the burst
    // is running. This keeps blanking entry to a single register stage
    // (vblank_q) before the first strobe.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        flush_d   = flush_q;
        do_commit = 1'b0;

        case (state_q)
            IDLE: begin
                if (slot_wr) state_d = WAIT;
            end
            WAIT: begin
                if (vblank_q || flush_q) begin
                    do_commit = pri_valid;
                    state_d   = COMMIT;
                end
            end
            COMMIT: begin
                if (vblank_q || flush_q) do_commit = pri_valid;
                else                     state_d   = WAIT;
            end
            default: state_d = IDLE;
        endcase

        // Clear before set: a write landing on the slot being committed
        // keeps it pending with the new value.
        if (do_commit) pending_d = pending_d & ~slot_onehot(pri_idx);
        pending_d = pending_d | wr_mask;

        if (pending_d == '0) state_d = IDLE;

        // The flush request lives until the pending set drains (or is
        // dropped a cycle later if nothing was pending).
        if (flush_wr)              flush_d = 1'b1;
        else if (pending_d == '0)  flush_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            flush_q   <= 1'b0;
            vblank_q  <= 1'b0;
            hold_out  <= '0;
            data_out  <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) shadow_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            flush_q   <= flush_d;
            vblank_q  <= (pixel_y >= 10'(V_VISIBLE));
            busy      <= (pending_d != '0);
            hold_out  <= do_commit ? slot_onehot(pri_idx) : '0;
            // shadow_q is read before this edge's write, so a same-cycle
            // rewrite commits the old value.
            if (do_commit) data_out <= shadow_q[pri_idx];
            if (slot_wr)   shadow_q[wr_idx] <= in_dato;
        end
    end

`ifdef VGA_COMMIT_OVR_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overwrite_flag <= 1'b0;
        end else if (slot_wr && pending_q[wr_idx]) begin
            overwrite_flag <= 1'b1;
        end else if (write_strobe && (port_id == PORT_OVR_CLR)) begin
            overwrite_flag <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_vga_commit_scheduler.sv
// Self-checking bench for vga_commit_scheduler: directed scenarios followed
// by a random port-write phase, all compared against a slot-set reference
// model and a strobe-order scoreboard.
module tb_vga_commit_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  port_id = 8'h00;
    logic [7:0]  in_dato = 8'h00;
    logic        write_strobe = 1'b0;
    logic [9:0]  pixel_y = 10'd0;
    logic [9:0]  hold_out;
    logic [7:0]  data_out;
    logic        busy;
`ifdef VGA_COMMIT_OVR_EN
    logic        overwrite_flag;
`endif

    int checks = 0;
    int errors = 0;
    bit run_chk = 1'b0;

    vga_commit_scheduler dut (
        .clock        (clock),
        .reset        (reset),
        .port_id      (port_id),
        .in_dato      (in_dato),
        .write_strobe (write_strobe),
        .pixel_y      (pixel_y),
        .hold_out     (hold_out),
        .data_out     (data_out),
        .busy         (busy)
`ifdef VGA_COMMIT_OVR_EN
        ,
        .overwrite_flag (overwrite_flag)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // Pending slots are a set; whenever the set is non-empty and commits are
    // allowed (blanking seen last cycle, or a flush requested) the smallest
    // member leaves the set with its stored value.
    logic [7:0]  shadow_m [10];
    bit          pend_m [10];
    bit          flush_m = 1'b0;
    bit          vblank_m = 1'b0;
    logic [9:0]  exp_hold = '0;
    logic [7:0]  exp_data = '0;
    logic        exp_busy = 1'b0;
    logic        exp_ovr = 1'b0;
    logic [11:0] exp_q[$];

    always @(posedge clock or negedge reset) begin : model
        bit np [10];
        int k;
        int s;
        bit any_new;
        if (!reset) begin
            for (int i = 0; i < 10; i++) begin
                shadow_m[i] <= 8'h00;
                pend_m[i]   <= 1'b0;
            end
            flush_m  <= 1'b0;
            vblank_m <= 1'b0;
            exp_hold <= '0;
            exp_data <= '0;
            exp_busy <= 1'b0;
            exp_ovr  <= 1'b0;
            exp_q.delete();
        end else begin
            np = pend_m;
            k = -1;
            for (int i = 9; i >= 0; i--) if (pend_m[i]) k = i;
            if (k >= 0 && (vblank_m || flush_m)) begin
                exp_hold <= 10'd1 << k;
                exp_data <= shadow_m[k];
                exp_q.push_back({4'(k), shadow_m[k]});
                np[k] = 1'b0;
            end else begin
                exp_hold <= '0;
            end
            if (write_strobe && port_id >= 8'h20 && port_id <= 8'h29) begin
                s = int'(port_id) - 32;
                if (pend_m[s]) exp_ovr <= 1'b1;
                shadow_m[s] <= in_dato;
                np[s] = 1'b1;
            end
`ifdef VGA_COMMIT_OVR_EN
            if (write_strobe && port_id == 8'h2E) exp_ovr <= 1'b0;
`endif
            any_new = 1'b0;
            for (int i = 0; i < 10; i++) any_new |= np[i];
            if (write_strobe && port_id == 8'h2F) flush_m <= 1'b1;
            else if (!any_new)                   flush_m <= 1'b0;
            pend_m   <= np;
            exp_busy <= any_new;
            vblank_m <= (pixel_y >= 10'd480);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-cycle comparison against the model plus strobe-order scoreboard.
    always @(negedge clock) begin
        logic [3:0] slot;
        if (run_chk) begin
            chk("hold_out", 32'(hold_out), 32'(exp_hold));
            chk("data_out", 32'(data_out), 32'(exp_data));
            chk("busy", 32'(busy), 32'(exp_busy));
`ifdef VGA_COMMIT_OVR_EN
            chk("overwrite_flag", 32'(overwrite_flag), 32'(exp_ovr));
`endif
            if (hold_out != '0) begin
                slot = '0;
                for (int i = 0; i < 10; i++) if (hold_out[i]) slot = 4'(i);
                if (exp_q.size() > 0) chk("strobe_order", 32'({slot, data_out}), 32'(exp_q.pop_front()));
                else                  chk("strobe_extra", 32'(hold_out), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic port_write(input logic [7:0] id, input logic [7:0] d);
        port_id      = id;
        in_dato      = d;
        write_strobe = 1'b1;
        cyc(1);
        write_strobe = 1'b0;
    endtask

    task automatic set_line(input logic [9:0] y);
        pixel_y = y;
    endtask

    task automatic wait_strobe(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            cyc(1);
            if (hold_out != '0) seen = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        int r;

        // reset
        #3 reset = 1'b0;
        cyc(3);
        reset = 1'b1;
        run_chk = 1'b1;
        cyc(1);
        chk("reset_hold", 32'(hold_out), 32'd0);
        chk("reset_data", 32'(data_out), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // single write in visible area, committed at blanking
        set_line(10'd100);
        cyc(2);
        port_write(8'h20, 8'h45);
        chk("t1_busy_pending", 32'(busy), 32'd1);
        chk("t1_no_early_strobe", 32'(hold_out), 32'd0);
        set_line(10'd480);
        wait_strobe(4, seen);
        chk("t1_strobe_seen", 32'(seen), 32'd1);
        chk("t1_hold", 32'(hold_out), 32'h001);
        chk("t1_data", 32'(data_out), 32'h45);
        cyc(1);
        chk("t1_single_pulse", 32'(hold_out), 32'd0);
        chk("t1_busy_clear", 32'(busy), 32'd0);
        set_line(10'd100);
        cyc(2);

        // three slots, committed lowest first with no gaps
        port_write(8'h22, 8'hA2);
        port_write(8'h20, 8'hA0);
        port_write(8'h29, 8'hA9);
        set_line(10'd480);
        wait_strobe(4, seen);
        chk("t2_strobe_seen", 32'(seen), 32'd1);
        chk("t2_hold0", 32'(hold_out), 32'h001);
        chk("t2_data0", 32'(data_out), 32'hA0);
        cyc(1);
        chk("t2_hold2", 32'(hold_out), 32'h004);
        chk("t2_data2", 32'(data_out), 32'hA2);
        cyc(1);
        chk("t2_hold9", 32'(hold_out), 32'h200);
        chk("t2_data9", 32'(data_out), 32'hA9);
        cyc(1);
        chk("t2_done", 32'(hold_out), 32'd0);
        set_line(10'd100);
        cyc(2);

        // overwrite of a pending slot keeps only the last value
        port_write(8'h23, 8'h11);
        port_write(8'h23, 8'h22);
`ifdef VGA_COMMIT_OVR_EN
        chk("t3_ovr_set", 32'(overwrite_flag), 32'd1);
`endif
        set_line(10'd480);
        wait_strobe(4, seen);
        chk("t3_strobe_seen", 32'(seen), 32'd1);
        chk("t3_hold", 32'(hold_out), 32'h008);
        chk("t3_data", 32'(data_out), 32'h22);
        cyc(1);
        chk("t3_single_commit", 32'(hold_out), 32'd0);
`ifdef VGA_COMMIT_OVR_EN
        chk("t3_ovr_sticky", 32'(overwrite_flag), 32'd1);
        port_write(8'h2E, 8'h00);
        chk("t3_ovr_cleared", 32'(overwrite_flag), 32'd0);
`endif
        set_line(10'd100);
        cyc(2);

        // flush commits without blanking
        set_line(10'd200);
        cyc(1);
        port_write(8'h21, 8'h5A);
        cyc(2);
        chk("t4_waits_for_blank", 32'(hold_out), 32'd0);
        port_write(8'h2F, 8'hFF);
        wait_strobe(2, seen);
        chk("t4_flush_strobe_seen", 32'(seen), 32'd1);
        chk("t4_hold", 32'(hold_out), 32'h002);
        chk("t4_data", 32'(data_out), 32'h5A);
        cyc(3);
        chk("t4_idle_busy", 32'(busy), 32'd0);

        // rewrite of slot 4 in the cycle it commits
        set_line(10'd100);
        cyc(1);
        port_write(8'h23, 8'h31);
        port_write(8'h24, 8'h41);
        set_line(10'd480);
        cyc(2);
        chk("t5_hold3", 32'(hold_out), 32'h008);
        chk("t5_data3", 32'(data_out), 32'h31);
        port_write(8'h24, 8'h42);
        chk("t5_hold4_old", 32'(hold_out), 32'h010);
        chk("t5_data4_old", 32'(data_out), 32'h41);
        chk("t5_busy_kept", 32'(busy), 32'd1);
        cyc(1);
        chk("t5_hold4_new", 32'(hold_out), 32'h010);
        chk("t5_data4_new", 32'(data_out), 32'h42);
        cyc(1);
        chk("t5_done", 32'(hold_out), 32'd0);
        chk("t5_busy_clear", 32'(busy), 32'd0);
        set_line(10'd100);
        cyc(2);

        // reset in the middle of a five-slot burst
        for (int i = 0; i < 5; i++) port_write(8'(8'h20 + i), 8'(8'h60 + i));
        set_line(10'd480);
        cyc(3);
        chk("t6_burst_running", 32'(hold_out), 32'h002);
        reset = 1'b0;
        #1;
        chk("t6_rst_hold", 32'(hold_out), 32'd0);
        chk("t6_rst_data", 32'(data_out), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        cyc(2);
        reset = 1'b1;
        wait_strobe(6, seen);
        chk("t6_no_strobe_after_reset", 32'(seen), 32'd0);
        chk("t6_busy_after_reset", 32'(busy), 32'd0);

        // random port traffic against the model
        set_line(10'd100);
        cyc(2);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                if (pixel_y >= 10'd480) set_line(10'($urandom_range(0, 479)));
                else                    set_line(10'($urandom_range(480, 524)));
            end
            r = $urandom_range(0, 15);
            if (r < 10)       port_id = 8'(8'h20 + r);
            else if (r == 10) port_id = 8'h2E;
            else if (r == 11) port_id = 8'h2F;
            else              port_id = 8'($urandom_range(0, 255));
            in_dato      = 8'($urandom_range(0, 255));
            write_strobe = ($urandom_range(0, 2) == 0);
            cyc(1);
        end
        write_strobe = 1'b0;
        set_line(10'd480);
        cyc(20);
        chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);

        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_commit_scheduler.md
# vga_commit_scheduler

Frame-synchronous write scheduler between the PicoBlaze port bus and the VGA display register bank. It captures microcontroller writes to the nine time/date/timer registers and the config-flag register into shadow slots. It commits them to the register bank one per clock, only during vertical blanking, so a displayed frame never shows a half-updated time. It sits beside the register-hold decoder and drives the bank's per-register hold strobes and data input.

## Interface

Parameters:
- `NUM_SLOTS`, 10: number of shadowed registers; fixed by the port map.
- `V_VISIBLE`, 480: first `pixel_y` value counted as vertical blanking.

Ports:
- `clock`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `port_id`  in  8  PicoBlaze port address.
- `in_dato`  in  8  PicoBlaze write data.
- `write_strobe`  in  1  PicoBlaze write qualifier.
- `pixel_y`  in  10  current scan line from the timing generator.
- `hold_out`  out  10  one-hot commit strobe to the register bank. Slot order: 0 seg_hora, 1 min_hora, 2 hora_hora, 3 dia_fecha, 4 mes_fecha, 5 jahr_fecha, 6 seg_timer, 7 min_timer, 8 hora_timer, 9 banderas_config.
- `data_out`  out  8  data accompanying `hold_out`.
- `busy`  out  1  high while any slot is pending.
- `overwrite_flag`  out  1  sticky overwrite indicator. Present only with `VGA_COMMIT_OVR_EN`.

## Operation

Slot capture:
- Slot k is written when `write_strobe`=1 and `port_id`=8'h20+k (k = 0..9).
- The write loads `shadow[k]` <= `in_dato` and sets `pending[k]`.
- Writing an already-pending slot overwrites its value; only the last value is committed.
- Any write to `port_id`=8'h2F sets `flush_req`. The data is ignored.
- All other port_ids are ignored.

Blanking:
- `vblank_q` is registered from (`pixel_y` >= `V_VISIBLE`).

States:
- IDLE: `pending`=0. Go to WAIT when a slot write occurs.
- WAIT: `pending`≠0 and no commit allowed. Go to COMMIT when `vblank_q`=1 or `flush_req`=1.
- COMMIT: each cycle, take the lowest-index pending slot k:
  - `hold_out` <= one-hot(k), `data_out` <= `shadow[k]`, clear `pending[k]`.
  - When `pending` becomes 0: go to IDLE and clear `flush_req`.
  - If `vblank_q` falls and `flush_req`=0: go to WAIT with the remaining slots held.
- Outside COMMIT, `hold_out`=0; `data_out` holds its last value.

Boundary conditions:
- A write to slot k in the same cycle that slot k commits: the commit uses the old shadow value, and `pending[k]` stays set with the new value. Set wins over clear.
- A write arriving during COMMIT joins the current burst if blanking is still active.
- Reset mid-burst discards all pending writes with no partial strobes.
- `flush_req` set while in IDLE with nothing pending is cleared on the next cycle.

## Timing

- All outputs are registered.
- Reset values: `hold_out`=0, `data_out`=0, `busy`=0, `overwrite_flag`=0, `pending`=0, `shadow`=0, `flush_req`=0, state IDLE.
- Write at edge t during blanking: `pending` is visible after t, and the `hold_out` pulse is driven from edge t+1.
- Burst of n pending slots: n consecutive single-cycle `hold_out` pulses, with no gaps.
- Blanking entry: `pixel_y` reaching 480 at edge t gives the first strobe at edge t+2.
- `busy` equals (`pending`≠0), registered with the same timing as `pending`.

## Configuration

- `VGA_COMMIT_OVR_EN` defined:
  - `overwrite_flag` is set when a slot write hits a slot whose `pending` bit is already 1.
  - It is cleared only by reset or by a write to `port_id` 8'h2E.
- Not defined: the port is absent, no sticky logic is built, and 8'h2E is ignored.

## Structure

Shared package `vga_regs_pkg`:
- Slot index constants `SLOT_SEG_HORA`..`SLOT_BANDERAS`.
- Base port address 8'h20, flush port 8'h2F, clear port 8'h2E.
- `NUM_SLOTS`, `V_VISIBLE`.
- State enum {IDLE, WAIT, COMMIT}.

Sub-module `slot_priority_enc`: 10-bit pending vector to 4-bit lowest-set index plus valid bit; purely combinational.

## Test plan

- Write 8'h45 to 8'h20 at `pixel_y`=100, then run to line 480 -> `hold_out`=10'b1 for one cycle, `data_out`=8'h45, then `busy`=0.
- Write slots 2, 0 and 9 during the visible area -> at blanking, three consecutive strobes in order 0, 2, 9.
- Write 8'h11 then 8'h22 to 8'h23 before blanking -> a single commit with `data_out`=8'h22; with the macro, `overwrite_flag`=1 until a write to 8'h2E.
- Write slot 1 at `pixel_y`=200, then write 8'h2F -> slot 1 commits within 2 cycles, without waiting for blanking.
- Write slot 4 in the same cycle that slot 4 commits -> the old value is strobed, and the new value is strobed on the following cycle.
- Assert `reset` low during a 5-slot burst -> all outputs 0 immediately, and no strobes after release.
